// File: rtl/lcd_sequencer.sv
// Control stage for the 4-bit HD44780 path: power-on wait, fixed init sequence, then host bytes split into nibble commands.
// Optional command watchdog is built when LCD_SEQ_TIMEOUT_EN is defined.
module lcd_sequencer #(
    parameter int unsigned POWER_ON_CYCLES   = 750000,
    parameter int unsigned INIT_LONG_CYCLES  = 205000,
    parameter int unsigned INIT_MID_CYCLES   = 5000,
    parameter int unsigned CMD_CYCLES        = 2000,
    parameter int unsigned CLEAR_CYCLES      = 82000,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES    = 400000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wrValid,
    input  logic        wrRS,
    input  logic [7:0]  wrData,
    output logic        wrReady,
    output logic        initDone,
    output logic        cmdError,
    output logic        sendCommand,
    output logic [4:0]  command,
    output logic [20:0] commandDelay,
    input  logic        commandDone
);

    localparam int unsigned CNT_W     = 20;
    localparam int unsigned DLY_W     = 21;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CMD_W     = 5;
    localparam int unsigned INIT_LAST = 13;

    // Elaboration-time range check on the delay parameters.
    if (POWER_ON_CYCLES == 0 || POWER_ON_CYCLES > (1 << CNT_W) ||
        INIT_LONG_CYCLES >= (1 << DLY_W) || INIT_MID_CYCLES >= (1 << DLY_W) ||
        CMD_CYCLES >= (1 << DLY_W) || CLEAR_CYCLES >= (1 << DLY_W) ||
        NIBBLE_GAP_CYCLES >= (1 << DLY_W) || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES >= (1 << DLY_W)) begin : g_param_check
        $error("lcd_sequencer: delay parameter out of range");
    end

    typedef enum logic [2:0] {
        RESET_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        HI_ISSUE,
        HI_WAIT,
        LO_ISSUE,
        LO_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               send_command_q, send_command_d;
    logic [CMD_W-1:0]   command_q, command_d;
    logic [DLY_W-1:0]   command_delay_q, command_delay_d;
    logic               wr_ready_q, wr_ready_d;
    logic               init_done_q, init_done_d;
`ifdef LCD_SEQ_TIMEOUT_EN
    logic [DLY_W-1:0]   wd_q, wd_d;
    logic               cmd_error_q, cmd_error_d;
`endif

    function automatic logic [3:0] rom_nibble(input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0, 4'd1, 4'd2: nib = 4'h3;
            4'd3, 4'd4:       nib = 4'h2;
            4'd5, 4'd7:       nib = 4'h8;
            4'd9:             nib = 4'h1;
            4'd11:            nib = 4'h6;
            4'd13:            nib = 4'hC;
            default:          nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Past the four wake-up nibbles, even entries are high nibbles and odd entries low nibbles.
    function automatic logic [DLY_W-1:0] rom_delay(input logic [IDX_W-1:0] idx);
        logic [DLY_W-1:0] dly;
        case (idx)
            4'd0:       dly = DLY_W'(INIT_LONG_CYCLES);
            4'd1:       dly = DLY_W'(INIT_MID_CYCLES);
            4'd2, 4'd3: dly = DLY_W'(CMD_CYCLES);
            4'd9:       dly = DLY_W'(CLEAR_CYCLES);
            default:    dly = idx[0] ? DLY_W'(CMD_CYCLES) : DLY_W'(NIBBLE_GAP_CYCLES);
        endcase
        return dly;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic [DLY_W-1:0] lo_delay(input logic rs, input logic [7:0] data);
        logic [DLY_W-1:0] dly;
        if (!rs && data[7:2] == 6'd0 && data[1:0] != 2'd0) begin
            dly = DLY_W'(CLEAR_CYCLES);
        end else begin
            dly = DLY_W'(CMD_CYCLES);
        end
        return dly;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= RESET_WAIT;
            cnt_q           <= '0;
            idx_q           <= '0;
            rs_q            <= 1'b0;
            data_q          <= '0;
            send_command_q  <= 1'b0;
            command_q       <= '0;
            command_delay_q <= '0;
            wr_ready_q      <= 1'b0;
            init_done_q     <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
            wd_q            <= '0;
            cmd_error_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            rs_q            <= rs_d;
            data_q          <= data_d;
            send_command_q  <= send_command_d;
            command_q       <= command_d;
            command_delay_q <= command_delay_d;
            wr_ready_q      <= wr_ready_d;
            init_done_q     <= init_done_d;
`ifdef LCD_SEQ_TIMEOUT_EN
            wd_q            <= wd_d;
            cmd_error_q     <= cmd_error_d;
`endif
        end
    end

    // Next state, then registered outputs derived from the state being entered.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        rs_d            = rs_q;
        data_d          = data_q;
        send_command_d  = 1'b0;
        command_d       = command_q;
        command_delay_d = command_delay_q;
        wr_ready_d      = 1'b0;
        init_done_d     = init_done_q;
`ifdef LCD_SEQ_TIMEOUT_EN
        wd_d            = wd_q;
        cmd_error_d     = cmd_error_q;
`endif

        case (state_q)
            RESET_WAIT: begin
                if (cnt_q == CNT_W'(POWER_ON_CYCLES - 1)) begin
                    state_d = INIT_ISSUE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT_ISSUE: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (commandDone) begin
                    if (idx_q == IDX_W'(INIT_LAST)) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = INIT_ISSUE;
                    end
                end
            end
            IDLE: begin
                if (wrValid) begin
                    rs_d    = wrRS;
                    data_d  = wrData;
                    state_d = HI_ISSUE;
                end
            end
            HI_ISSUE: state_d = HI_WAIT;
            HI_WAIT: begin
                if (commandDone) begin
                    state_d = LO_ISSUE;
                end
            end
            LO_ISSUE: state_d = LO_WAIT;
            LO_WAIT: begin
                if (commandDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = RESET_WAIT;
        endcase

`ifdef LCD_SEQ_TIMEOUT_EN
        // Watchdog: restarts at each strobe, trips when a WAIT state sees no completion in time.
        case (state_q)
            INIT_ISSUE, HI_ISSUE, LO_ISSUE: wd_d = DLY_W'(1);
            INIT_WAIT, HI_WAIT, LO_WAIT: begin
                wd_d = wd_q + DLY_W'(1);
                if (!commandDone && wd_q == DLY_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESET_WAIT;
                    cnt_d       = '0;
                    cmd_error_d = 1'b1;
                    init_done_d = 1'b0;
                end
            end
            default: wd_d = '0;
        endcase
`endif

        case (state_d)
            INIT_ISSUE: begin
                send_command_d  = 1'b1;
                command_d       = {1'b0, rom_nibble(idx_d)};
                command_delay_d = rom_delay(idx_d);
            end
            HI_ISSUE: begin
                send_command_d  = 1'b1;
                command_d       = {rs_d, data_d[7:4]};
                command_delay_d = DLY_W'(NIBBLE_GAP_CYCLES);
            end
            LO_ISSUE: begin
                send_command_d  = 1'b1;
                command_d       = {rs_q, data_q[3:0]};
                command_delay_d = lo_delay(rs_q, data_q);
            end
            default: ;
        endcase

        wr_ready_d = (state_d == IDLE);
    end

    assign sendCommand  = send_command_q;
    assign command      = command_q;
    assign commandDelay = command_delay_q;
    assign wrReady      = wr_ready_q;
    assign initDone     = init_done_q;
`ifdef LCD_SEQ_TIMEOUT_EN
    assign cmdError     = cmd_error_q;
`else
    assign cmdError     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a behavioural transfer stage that answers after commandDelay+5 cycles.
module tb_lcd_sequencer;

    localparam int B_P    = 300;
    localparam int B_LONG = 60;
    localparam int B_MID  = 40;
    localparam int B_CMD  = 20;
    localparam int B_CLR  = 50;
    localparam int B_GAP  = 5;
    localparam int B_TO   = 200;

    localparam int SEL_INIT  = 0;
    localparam int SEL_READY = 1;
    localparam int SEL_ERR   = 2;

    typedef struct {
        int          cyc;
        logic [4:0]  cmd;
        logic [20:0] dly;
    } strobe_t;

    logic        CLK;
    logic        RST;
    logic        wrValid;
    logic        wrRS;
    logic [7:0]  wrData;
    logic        wrReady;
    logic        initDone;
    logic        cmdError;
    logic        sendCommand;
    logic [4:0]  command;
    logic [20:0] commandDelay;
    logic        commandDone;

    int      cyc = 0;
    int      n_chk = 0;
    int      n_fail = 0;
    int      cd_timer = 0;
    bit      model_en;
    bit      inject_done;
    strobe_t strobes[$];
    int      dones[$];

    int exp_nib[14] = '{3, 3, 3, 2, 2, 8, 0, 8, 0, 1, 0, 6, 0, 12};
    int exp_dly[14] = '{B_LONG, B_MID, B_CMD, B_CMD, B_GAP, B_CMD, B_GAP,
                        B_CMD, B_GAP, B_CLR, B_GAP, B_CMD, B_GAP, B_CMD};

    lcd_sequencer #(
        .POWER_ON_CYCLES  (B_P),
        .INIT_LONG_CYCLES (B_LONG),
        .INIT_MID_CYCLES  (B_MID),
        .CMD_CYCLES       (B_CMD),
        .CLEAR_CYCLES     (B_CLR),
        .NIBBLE_GAP_CYCLES(B_GAP),
        .TIMEOUT_CYCLES   (B_TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wrValid     (wrValid),
        .wrRS        (wrRS),
        .wrData      (wrData),
        .wrReady     (wrReady),
        .initDone    (initDone),
        .cmdError    (cmdError),
        .sendCommand (sendCommand),
        .command     (command),
        .commandDelay(commandDelay),
        .commandDone (commandDone)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Transfer-stage model: logs every strobe and pulses commandDone delay+5 cycles later.
    initial begin
        strobe_t s;
        commandDone = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            commandDone = 1'b0;
            if (sendCommand) begin
                s.cyc = cyc;
                s.cmd = command;
                s.dly = commandDelay;
                strobes.push_back(s);
            end
            if (inject_done) begin
                commandDone = 1'b1;
                inject_done = 1'b0;
            end else if (!model_en) begin
                cd_timer = 0;
            end else if (sendCommand) begin
                cd_timer = int'(commandDelay) + 5;
            end else if (cd_timer > 0) begin
                cd_timer = cd_timer - 1;
                if (cd_timer == 0) begin
                    commandDone = 1'b1;
                    dones.push_back(cyc);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            SEL_INIT:  return initDone;
            SEL_READY: return wrReady;
            default:   return cmdError;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i <= budget; i++) begin
            if (sig_of(sel)) begin
                at = cyc;
                break;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_send"},  32'(sendCommand),  32'd0);
        check({tag, "_cmd"},   32'(command),      32'd0);
        check({tag, "_dly"},   32'(commandDelay), 32'd0);
        check({tag, "_ready"}, 32'(wrReady),      32'd0);
        check({tag, "_init"},  32'(initDone),     32'd0);
        check({tag, "_err"},   32'(cmdError),     32'd0);
    endtask

    task automatic check_init(input string tag, input int rel);
        int at;
        wait_for(SEL_INIT, 5000, at);
        check({tag, "_init_done"}, 32'(initDone), 32'd1);
        check({tag, "_n_strobes"}, 32'(strobes.size()), 32'd14);
        check({tag, "_n_dones"}, 32'(dones.size()), 32'd14);
        if (strobes.size() > 0) check({tag, "_first_at"}, 32'(strobes[0].cyc - rel), 32'(B_P));
        for (int i = 0; i < 14 && i < int'(strobes.size()); i++) begin
            check($sformatf("%s_cmd%0d", tag, i), 32'(strobes[i].cmd), 32'(exp_nib[i]));
            check($sformatf("%s_dly%0d", tag, i), 32'(strobes[i].dly), 32'(exp_dly[i]));
            if (i > 0 && i - 1 < int'(dones.size()))
                check($sformatf("%s_space%0d", tag, i), 32'(strobes[i].cyc), 32'(dones[i-1] + 1));
        end
        if (dones.size() == 14) check({tag, "_rise_at"}, 32'(at), 32'(dones[13] + 1));
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] data, output int acc);
        int r;
        wait_for(SEL_READY, 2000, r);
        check("wr_ready_before", 32'(wrReady), 32'd1);
        wrValid = 1'b1;
        wrRS    = rs;
        wrData  = data;
        @(posedge CLK);
        #1;
        wrValid = 1'b0;
        acc     = cyc;
    endtask

    logic       t_rs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_dat[7] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h80, 8'h04, 8'h01};
    int         t_dly[7] = '{B_CLR, B_CLR, B_CLR, B_CMD, B_CMD, B_CMD, B_CMD};

    logic       b_rs[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] b_dat[3] = '{8'hA5, 8'h3C, 8'h7E};
    int         b_cmd[6] = '{'h1A, 'h15, 'h03, 'h0C, 'h17, 'h1E};

    initial begin
        int acc;
        int at;
        int rel;
        int idx;
        logic rdy;
        RST = 1'b1; wrValid = 1'b0; wrRS = 1'b0; wrData = 8'h00;
        model_en = 1'b1; inject_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero("rst");

        RST = 1'b0;
        rel = cyc;
        strobes.delete(); dones.delete();
        check_init("pwr", rel);

        // Single data byte 0x41.
        strobes.delete(); dones.delete();
        write_byte(1'b1, 8'h41, acc);
        check("dw_ready_low", 32'(wrReady), 32'd0);
        check("dw_strobe", 32'(sendCommand), 32'd1);
        wait_for(SEL_READY, 2000, at);
        check("dw_n", 32'(strobes.size()), 32'd2);
        if (strobes.size() == 2 && dones.size() == 2) begin
            check("dw_hi_at",  32'(strobes[0].cyc), 32'(acc));
            check("dw_hi_cmd", 32'(strobes[0].cmd), 32'h14);
            check("dw_hi_dly", 32'(strobes[0].dly), 32'(B_GAP));
            check("dw_lo_at",  32'(strobes[1].cyc), 32'(dones[0] + 1));
            check("dw_lo_cmd", 32'(strobes[1].cmd), 32'h11);
            check("dw_lo_dly", 32'(strobes[1].dly), 32'(B_CMD));
            check("dw_ready_at", 32'(at), 32'(dones[1] + 1));
        end

        // Long-delay rule table.
        for (int k = 0; k < 7; k++) begin
            strobes.delete(); dones.delete();
            write_byte(t_rs[k], t_dat[k], acc);
            wait_for(SEL_READY, 2000, at);
            check($sformatf("ld%0d_n", k), 32'(strobes.size()), 32'd2);
            if (strobes.size() == 2) begin
                check($sformatf("ld%0d_hi_cmd", k), 32'(strobes[0].cmd), 32'({t_rs[k], t_dat[k][7:4]}));
                check($sformatf("ld%0d_hi_dly", k), 32'(strobes[0].dly), 32'(B_GAP));
                check($sformatf("ld%0d_lo_cmd", k), 32'(strobes[1].cmd), 32'({t_rs[k], t_dat[k][3:0]}));
                check($sformatf("ld%0d_lo_dly", k), 32'(strobes[1].dly), 32'(t_dly[k]));
            end
        end

        // Back-to-back bytes with wrValid held high.
        strobes.delete(); dones.delete();
        wait_for(SEL_READY, 2000, at);
        idx = 0;
        wrValid = 1'b1; wrRS = b_rs[0]; wrData = b_dat[0];
        for (int i = 0; i < 2000 && idx < 3; i++) begin
            rdy = wrReady;
            @(posedge CLK);
            #1;
            if (rdy) begin
                idx++;
                if (idx < 3) begin
                    wrRS = b_rs[idx]; wrData = b_dat[idx];
                end else begin
                    wrValid = 1'b0;
                end
            end
        end
        wrValid = 1'b0;
        check("b2b_accepted", 32'(idx), 32'd3);
        wait_for(SEL_READY, 2000, at);
        check("b2b_n", 32'(strobes.size()), 32'd6);
        for (int i = 0; i < 6 && i < int'(strobes.size()); i++) begin
            check($sformatf("b2b_cmd%0d", i), 32'(strobes[i].cmd), 32'(b_cmd[i]));
            if (i > 0 && i - 1 < int'(dones.size()))
                check($sformatf("b2b_space%0d", i), 32'(strobes[i].cyc),
                      32'(dones[i-1] + ((i % 2 == 1) ? 1 : 2)));
        end

        // Reset during HI_WAIT, then a stale completion during the power-on wait.
        write_byte(1'b1, 8'h55, acc);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_en = 1'b0;
        @(posedge CLK);
        #1;
        check_zero("mid");
        RST = 1'b0;
        rel = cyc;
        strobes.delete(); dones.delete();
        model_en = 1'b1;
        repeat (50) @(posedge CLK);
        #1;
        inject_done = 1'b1;
        check("mid_wait_ready", 32'(wrReady), 32'd0);
        check_init("rinit", rel);

`ifdef LCD_SEQ_TIMEOUT_EN
        // Withheld completion trips the watchdog and re-runs init.
        model_en = 1'b0;
        write_byte(1'b0, 8'h38, acc);
        wait_for(SEL_ERR, B_TO + 50, at);
        check("wd_err", 32'(cmdError), 32'd1);
        check("wd_err_at", 32'(at), 32'(acc + B_TO));
        check("wd_init_clr", 32'(initDone), 32'd0);
        strobes.delete(); dones.delete();
        model_en = 1'b1;
        check_init("wd", at);
        check("wd_err_sticky", 32'(cmdError), 32'd1);
`else
        check("no_wd_err", 32'(cmdError), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
